fifo_modport: RTL and testbench
===============================

# fifo_modport

Synchronous first-in/first-out buffer for 8-bit data words, with a single clock. A producer pushes words with `wr` and a consumer pops them in order with `rd`. Registered `full` and `empty` flags provide back-pressure. The block sits between the stimulus driver and the checker: all inputs are sampled on the rising edge of `clk`, and all outputs change only on that edge or on reset.

## Interface
- `DATA_WIDTH`, default 8: width of one stored word.
- `DEPTH`, default 16: number of storage entries; must be a power of two and at least 2.
- `clk` input 1: clock; everything is sampled on its rising edge.
- `rst` input 1: reset, asynchronous and active-low; resets the block when 0.
- `wr` input 1: write request; pushes `data_in` when the FIFO is not full.
- `rd` input 1: read request; pops the oldest word onto `data_out` when the FIFO is not empty.
- `data_in` input `DATA_WIDTH`: word to be written.
- `data_out` output `DATA_WIDTH`: registered read data.
- `full` output 1: registered; 1 when `DEPTH` words are stored.
- `empty` output 1: registered; 1 when no words are stored.

## Operation
- Storage is a `DEPTH`-entry array with a write pointer, a read pointer and an occupancy counter.
  - The counter spans 0..`DEPTH`, so it needs log2(`DEPTH`)+1 bits.
  - Both pointers are log2(`DEPTH`) bits and wrap from `DEPTH`-1 to 0 naturally.
- Reset (`rst`=0, asynchronous):
  - Pointers and counter go to 0.
  - `data_out` = 0, `empty` = 1, `full` = 0.
  - Array contents are not cleared and need not be.
- Accepted write (`wr`=1 and `full`=0 at the edge):
  - `mem[wptr]` ← `data_in`.
  - `wptr` increments.
- Accepted read (`rd`=1 and `empty`=0 at the edge):
  - `data_out` ← `mem[rptr]`.
  - `rptr` increments.
- Rejected requests:
  - A write while full is ignored: no state change, no error flag.
  - A read while empty is ignored and `data_out` holds its previous value.
- Simultaneous `wr` and `rd`:
  - Not full and not empty: both are performed and the count is unchanged.
  - Empty: only the write is performed; the read is ignored, so there is no fall-through.
  - Full: both are performed, the count stays `DEPTH` and `full` stays 1.
- Counter update: +1 on write-only, −1 on read-only, unchanged otherwise.
- Flags are recomputed from the next-state count and registered:
  - `empty` = (count_next == 0).
  - `full` = (count_next == `DEPTH`).
- `data_out` changes only on an accepted read or on reset.
- Data ordering is strict FIFO, including across pointer wrap-around.

## Timing
- Write-to-read latency:
  - A word written at edge N can be read by a read request sampled at edge N+1.
  - It appears on `data_out` after edge N+1.
- Read latency: 1 cycle. `data_out` is valid after the edge at which the read request was sampled.
- Flag update timing:
  - `empty` falls after the edge that accepts the first write.
  - `full` rises after the edge that accepts the `DEPTH`-th outstanding write.
  - Flags never lag the stored-data state by more than that edge.
- Input timing: the driver changes inputs 1 time unit after the rising edge, and the monitor samples 1 time unit before it. All inputs must therefore be stable across the edge; no combinational paths run from inputs to outputs.
- Reset timing:
  - Reset asserted mid-operation clears state immediately, regardless of `clk`.
  - Reset release is synchronous-safe: the first accepted operation is at the first rising edge with `rst`=1.
- Requests presented while `rst`=0 are discarded.

## Test plan
- Reset check: hold `rst`=0 for 2 cycles, then release → `empty`=1, `full`=0, `data_out`=0x00; a read at the first edge leaves `data_out`=0x00.
- Fill and drain: write 0x01..0x10 (16 words) → `full`=1 after the 16th edge. A 17th write of 0xFF is ignored. Then read 16 times → `data_out` = 0x01..0x10 in order, and `empty`=1 after the last read.
- Empty read: read with `empty`=1 → `data_out` holds its previous value and the pointers do not move.
- Simultaneous read/write:
  - With 3 words stored, assert `wr`+`rd` with `data_in`=0xA5 → `data_out`=first word, count stays 3.
  - With the FIFO full, assert both → `full` stays 1 and the popped word is the oldest one.
  - With the FIFO empty, assert both with 0x5A → `empty`=0, `data_out` unchanged; the next read returns 0x5A.
- Wrap-around: perform 40 interleaved writes/reads with the count held between 1 and 16 → every read matches the scoreboard order.
- Mid-operation reset: after writing 5 words, pulse `rst`=0 between clock edges → `empty`=1 and `data_out`=0 immediately; a subsequent write/read returns the new data only.

Source files
------------

// File: rtl/fifo_modport.sv
// fifo_modport: single-clock FIFO with registered full/empty flags and registered read data
module fifo_modport #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [AW:0]           r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [AW:0]           w_count_next;
  // a write while full still lands when a read frees the slot on the same edge
  assign w_wr_ok = wr && (!r_full || rd);
  assign w_rd_ok = rd && !r_empty;
  // occupancy follows write-only / read-only; simultaneous accepted ops cancel out
  always_comb begin
    w_count_next = (w_wr_ok && !w_rd_ok) ? r_count + (AW+1)'(1) :
                   (w_rd_ok && !w_wr_ok) ? r_count - (AW+1)'(1) : r_count;
  end
  // storage array is never cleared, so it carries no reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= data_in;
  end
  // pointers, count, flags and read data register together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_data_out <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
      if (w_rd_ok) begin
        r_data_out <= r_mem[r_rptr];
        r_rptr     <= r_rptr + AW'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == (AW+1)'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end
  assign data_out = r_data_out;
  assign full     = r_full;
  assign empty    = r_empty;
endmodule

// File: tb/tb_fifo_modport.sv
// tb_fifo_modport: random and directed FIFO checks against a queue reference model
module tb_fifo_modport;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst;
  logic wr;
  logic rd;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic full;
  logic empty;
  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_dout;

  fifo_modport #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_dout"}, data_out, exp_dout);
    chk({tag, "_empty"}, empty, q.size() == 0);
    chk({tag, "_full"}, full, q.size() == DEPTH);
  endtask

  // one clock: drive, model the edge from the pre-edge occupancy, then compare
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit was_full, was_empty, rd_ok, wr_ok;
    wr = w; rd = r; data_in = d;
    @(posedge clk);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    rd_ok = r && !was_empty;
    wr_ok = w && (!was_full || r);
    if (rd_ok) exp_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    #1;
    wr = 1'b0; rd = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    bit w, r;
    rst = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
    exp_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1'b1;
    cycle(1'b0, 1'b1, 8'h00, "rd_after_reset");
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, DW'(i), "fill");
    chk("fill_full_const", full, 1);
    cycle(1'b1, 1'b0, 8'hFF, "write_when_full");
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00, "drain");
      chk("drain_order", data_out, i);
    end
    chk("drain_empty_const", empty, 1);
    cycle(1'b0, 1'b1, 8'h00, "empty_read");
    chk("empty_read_hold", data_out, 8'h10);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h30 + DW'(i), "pre3");
    cycle(1'b1, 1'b1, 8'hA5, "both_3");
    chk("both_3_first", data_out, 8'h30);
    chk("both_3_count", q.size(), 3);
    for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0, 8'h40 + DW'(i), "to_full");
    cycle(1'b1, 1'b1, 8'hC3, "both_full");
    chk("both_full_flag", full, 1);
    chk("both_full_oldest", data_out, 8'h31);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, "drain2");
    cycle(1'b1, 1'b1, 8'h5A, "both_empty");
    chk("both_empty_flag", empty, 0);
    cycle(1'b0, 1'b1, 8'h00, "after_both_empty");
    chk("after_both_empty_val", data_out, 8'h5A);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'($urandom), "prewrap");
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom); r = 1'($urandom);
      if (q.size() == DEPTH && w && !r) r = 1'b1;
      if (q.size() == 1 && r && !w) w = 1'b1;
      cycle(w, r, DW'($urandom), "wrap");
    end
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 1'($urandom), DW'($urandom), "random");
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, "drain3");
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'h70 + DW'(i), "pre_rst");
    #2 rst = 1'b0;
    #1;
    q.delete(); exp_dout = '0;
    chk_all("mid_reset");
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset_idle");
    cycle(1'b1, 1'b0, 8'h99, "new_write");
    cycle(1'b0, 1'b1, 8'h00, "new_read");
    chk("new_read_val", data_out, 8'h99);
    cycle(1'b0, 1'b1, 8'h00, "new_read_empty");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
